// File: rtl/if_stage_pkg.sv
// Shared CPU front-end definitions: fetch window constants and the IF/ID bundle.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0003_FFFC;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        fetch_err;
  } ifid_t;

  // A fetch is legal only when word-aligned and inside the instruction window.
  function automatic logic fetch_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= IM_BASE) && (pc <= IM_LIMIT);
  endfunction

endpackage

// File: rtl/if_stage_pc_unit.sv
// PC register with stall/redirect/sequential next-PC selection and fetch legality.
module pc_unit
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_o,
  output logic        illegal_o
);

  logic [31:0] pc_q, pc_d;

  // Redirect is deliberately dropped under stall; ID re-asserts it afterwards.
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (redirect) pc_d = redirect_pc;
      else          pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o      = pc_q;
  assign illegal_o = !fetch_legal(pc_q);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the IM address, captures the IF/ID register
// (delayed-branch, no squash on redirect) and counts accepted instructions.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_fetch_err,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic        illegal;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] fcnt_q, fcnt_d;

  pc_unit u_pc (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_o        (pc),
    .illegal_o   (illegal)
  );

  always_comb begin
    ifid_d = ifid_q;
    fcnt_d = fcnt_q;
    if (!stall) begin
      ifid_d.pc = pc;
      if (flush) begin
        ifid_d.instr     = NOP_WORD;
        ifid_d.valid     = 1'b0;
        ifid_d.fetch_err = 1'b0;
      end else begin
        // Illegal fetches still occupy a slot so the error travels down the pipe.
        ifid_d.instr     = illegal ? NOP_WORD : im_instr;
        ifid_d.valid     = 1'b1;
        ifid_d.fetch_err = illegal;
        fcnt_d           = fcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ifid_q <= '{instr: NOP_WORD, pc: RESET_PC, valid: 1'b0, fetch_err: 1'b0};
      fcnt_q <= '0;
    end else begin
      ifid_q <= ifid_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign im_pc        = pc;
  assign id_instr     = ifid_q.instr;
  assign id_pc        = ifid_q.pc;
  assign id_pc8       = ifid_q.pc + 32'd8;
  assign id_valid     = ifid_q.valid;
  assign id_fetch_err = ifid_q.fetch_err;
  assign fetch_count  = fcnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns im_pc ^ 32'hA5A5_0000.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, flush;
  logic [31:0] redirect_pc;
  logic [31:0] im_pc, im_instr, id_instr, id_pc, id_pc8, fetch_count;
  logic        id_valid, id_fetch_err;

  int n_chk  = 0;
  int n_pass = 0;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .flush        (flush),
    .im_pc        (im_pc),
    .im_instr     (im_instr),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc8       (id_pc8),
    .id_valid     (id_valid),
    .id_fetch_err (id_fetch_err),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;
  assign im_instr = im_pc ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; flush = 1'b0; redirect_pc = '0;
    tick();
    chk("rst_pc",     im_pc,        32'h3000);
    chk("rst_idpc",   id_pc,        32'h3000);
    chk("rst_instr",  id_instr,     32'h0);
    chk("rst_valid",  id_valid,     1'b0);
    chk("rst_err",    id_fetch_err, 1'b0);
    chk("rst_cnt",    fetch_count,  32'd0);

    // Free run
    reset = 1'b1;
    tick();
    chk("c1_idpc",  id_pc,    32'h3000);
    chk("c1_valid", id_valid, 1'b1);
    chk("c1_instr", id_instr, 32'hA5A5_3000);
    chk("c1_pc8",   id_pc8,   32'h3008);
    tick(); tick();
    chk("c3_idpc", id_pc,       32'h3008);
    chk("c3_cnt",  fetch_count, 32'd3);
    chk("c3_impc", im_pc,       32'h300C);
    tick();
    chk("c4_impc", im_pc, 32'h3010);

    // Redirect with delay slot
    redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect = 1'b0;
    chk("ds_idpc",  id_pc,    32'h3010);
    chk("ds_instr", id_instr, 32'hA5A5_3010);
    chk("ds_valid", id_valid, 1'b1);
    chk("ds_impc",  im_pc,    32'h3100);
    tick();
    chk("tgt_idpc",  id_pc,       32'h3100);
    chk("tgt_valid", id_valid,    1'b1);
    chk("tgt_cnt",   fetch_count, 32'd6);

    // Stall with redirect ignored
    redirect = 1'b1; redirect_pc = 32'h3020;
    tick();
    chk("pre_stall_impc", im_pc, 32'h3020);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_impc", im_pc,       32'h3020);
      chk("st_idpc", id_pc,       32'h3104);
      chk("st_cnt",  fetch_count, 32'd7);
    end
    stall = 1'b0; redirect = 1'b0;
    tick();
    chk("rel_idpc", id_pc,       32'h3020);
    chk("rel_impc", im_pc,       32'h3024);
    chk("rel_cnt",  fetch_count, 32'd8);

    // Flush with redirect
    flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h3200;
    tick();
    flush = 1'b0;
    chk("fl_valid", id_valid,    1'b0);
    chk("fl_instr", id_instr,    32'h0);
    chk("fl_cnt",   fetch_count, 32'd8);
    chk("fl_impc",  im_pc,       32'h3200);

    // Illegal fetches: misaligned, below base, then recovery
    redirect_pc = 32'h3002;
    tick();
    chk("ma_pre_idpc", id_pc, 32'h3200);
    redirect_pc = 32'h2FFC;
    tick();
    chk("ma_instr", id_instr,     32'h0);
    chk("ma_err",   id_fetch_err, 1'b1);
    chk("ma_valid", id_valid,     1'b1);
    redirect_pc = 32'h3004;
    tick();
    chk("lo_idpc",  id_pc,        32'h2FFC);
    chk("lo_instr", id_instr,     32'h0);
    chk("lo_err",   id_fetch_err, 1'b1);
    redirect = 1'b0;
    tick();
    chk("ok_err",   id_fetch_err, 1'b0);
    chk("ok_instr", id_instr,     32'hA5A5_3004);
    chk("ok_cnt",   fetch_count,  32'd12);

    // Upper limit: last legal word, then first illegal
    redirect = 1'b1; redirect_pc = 32'h0003_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    chk("lim_err",   id_fetch_err, 1'b0);
    chk("lim_instr", id_instr,     32'hA5A6_FFFC);
    tick();
    chk("over_idpc", id_pc,        32'h0004_0000);
    chk("over_err",  id_fetch_err, 1'b1);
    chk("over_cnt",  fetch_count,  32'd15);

    // Reset during stall
    stall = 1'b1; reset = 1'b0;
    tick();
    chk("mr_impc",  im_pc,       32'h3000);
    chk("mr_valid", id_valid,    1'b0);
    chk("mr_cnt",   fetch_count, 32'd0);
    chk("mr_err",   id_fetch_err, 1'b0);
    stall = 1'b0; reset = 1'b1;
    tick();
    chk("rs_idpc",  id_pc,       32'h3000);
    chk("rs_valid", id_valid,    1'b1);
    chk("rs_cnt",   fetch_count, 32'd1);
    chk("rs_impc",  im_pc,       32'h3004);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
